// File: rtl/synth_pkg.sv
// Shared types and constants for the synth channel.
// Holds the waveform/envelope enums and the sine table with its lookup.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_PULSE = 2'b00,
    WAVE_TRI   = 2'b01,
    WAVE_SINE  = 2'b10,
    WAVE_SAW   = 2'b11
  } wave_e;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_e;

  // First quarter of the 256-entry sine: round(127*sin(pi*k/128)).
  localparam logic [7:0] SINE_Q [65] = '{
    8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd16,  8'd19,  8'd22,
    8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
    8'd49,  8'd51,  8'd54,  8'd57,  8'd60,  8'd63,  8'd65,  8'd68,
    8'd71,  8'd73,  8'd76,  8'd78,  8'd81,  8'd83,  8'd85,  8'd88,
    8'd90,  8'd92,  8'd94,  8'd96,  8'd98,  8'd100, 8'd102, 8'd104,
    8'd106, 8'd107, 8'd109, 8'd111, 8'd112, 8'd113, 8'd115, 8'd116,
    8'd117, 8'd118, 8'd120, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124,
    8'd125, 8'd125, 8'd126, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127,
    8'd127
  };

  // Full 256-entry table by symmetry: mirror inside each half,
  // negative half is 255 minus the positive half.
  function automatic logic [7:0] sine8(input logic [7:0] idx);
    logic [7:0] k;
    logic [7:0] m;
    logic [7:0] s;
    k = {1'b0, idx[6:0]};
    m = (k > 8'd64) ? 8'd128 - k : k;
    s = 8'd128 + SINE_Q[m[6:0]];
    return idx[7] ? 8'd255 - s : s;
  endfunction

endpackage

// File: rtl/channel_nco_if.sv
// Control/sample bundle for one synth channel.
// master drives tick/gate/tone settings; slave returns out/out_valid/active.
interface channel_nco_if #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 11,
  parameter int ENV_W   = 8
);
  logic               tick;
  logic               gate;
  logic [PHASE_W-1:0] phase_inc;
  logic [1:0]         waveform;
  logic [7:0]         duty;
  logic [ENV_W-1:0]   env_rate;
  logic [OUT_W-1:0]   out;
  logic               out_valid;
  logic               active;

  modport master (
    output tick, gate, phase_inc, waveform, duty, env_rate,
    input  out, out_valid, active
  );

  modport slave (
    input  tick, gate, phase_inc, waveform, duty, env_rate,
    output out, out_valid, active
  );
endinterface

// File: rtl/channel_env.sv
// Linear attack/release envelope with gate edge detection.
// Ports: clk, rst (async low), tick, gate, env_rate -> level, active.
module channel_env
  import synth_pkg::*;
#(
  parameter int ENV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             gate,
  input  logic [ENV_W-1:0] env_rate,
  output logic [ENV_W-1:0] level,
  output logic             active
);

  localparam logic [ENV_W-1:0] LMAX = '1;

  env_e             st;
  env_e             st_t;
  env_e             st_n;
  logic             gate_q;
  logic             rise;
  logic [ENV_W-1:0] rate;
  logic [ENV_W-1:0] lvl_n;
  logic [ENV_W:0]   up;

  assign rise = gate & ~gate_q;
  assign rate = (env_rate == '0) ? ENV_W'(1) : env_rate;
  assign up   = {1'b0, level} + {1'b0, rate};

  // Gate events move the state first; the tick step then runs
  // in that new state and may finish the segment.
  always_comb begin
    st_t = st;
    unique case (st)
      ENV_IDLE:    if (rise)  st_t = ENV_ATTACK;
      ENV_ATTACK:  if (!gate) st_t = ENV_RELEASE;
      ENV_SUSTAIN: if (!gate) st_t = ENV_RELEASE;
      ENV_RELEASE: if (rise)  st_t = ENV_ATTACK;
      default:     st_t = ENV_IDLE;
    endcase
    st_n  = st_t;
    lvl_n = level;
    if (tick) begin
      if (st_t == ENV_ATTACK) begin
        lvl_n = up[ENV_W] ? LMAX : up[ENV_W-1:0];
        if (lvl_n == LMAX) st_n = ENV_SUSTAIN;
      end else if (st_t == ENV_RELEASE) begin
        lvl_n = (level > rate) ? level - rate : '0;
        if (lvl_n == '0) st_n = ENV_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= ENV_IDLE;
      level  <= '0;
      gate_q <= 1'b0;
    end else begin
      st     <= st_n;
      level  <= lvl_n;
      gate_q <= gate;
    end
  end

  assign active = (st != ENV_IDLE);

endmodule

// File: rtl/channel_nco.sv
// One synth voice: phase accumulator, waveform shaper, envelope multiply.
// Ports: clk, rst (async low), bus (slave: tone in, out/out_valid/active).
module channel_nco
  import synth_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 11,
  parameter int ENV_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  channel_nco_if.slave bus
);

  logic [ENV_W-1:0]   level;
  logic               env_on;
  logic               gate_q;
  logic               rise;
  logic               run;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] inc_a;
  wave_e              wave_a;
  logic [7:0]         duty_a;
  logic [PHASE_W:0]   sum;
  logic [7:0]         idx;
  logic [7:0]         raw;
  logic [OUT_W-1:0]   scaled;
  logic [OUT_W-1:0]   mixed;
  logic [OUT_W-1:0]   out_q;
  logic               valid_q;

  channel_env #(.ENV_W(ENV_W)) u_env (
    .clk      (clk),
    .rst      (rst),
    .tick     (bus.tick),
    .gate     (bus.gate),
    .env_rate (bus.env_rate),
    .level    (level),
    .active   (env_on)
  );

  // A rising gate starts the note this very cycle, so a coincident
  // tick already advances the phase.
  assign rise = bus.gate & ~gate_q;
  assign run  = env_on | rise;
  assign sum  = {1'b0, phase} + {1'b0, inc_a};
  assign idx  = phase[PHASE_W-1 -: 8];

  always_comb begin
    raw = '0;
    unique case (wave_a)
      WAVE_PULSE: raw = (idx < duty_a) ? 8'hFF : 8'h00;
      WAVE_TRI:   raw = idx[7] ? {~idx[6:0], 1'b0} : {idx[6:0], 1'b0};
      WAVE_SINE:  raw = sine8(idx);
      WAVE_SAW:   raw = idx;
      default:    raw = '0;
    endcase
  end

  assign scaled = OUT_W'(raw) << (OUT_W - 8);
  assign mixed  = OUT_W'(({{ENV_W{1'b0}}, scaled} *
                          {{OUT_W{1'b0}}, level}) >> ENV_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gate_q  <= 1'b0;
      phase   <= '0;
      inc_a   <= '0;
      wave_a  <= WAVE_PULSE;
      duty_a  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      gate_q <= bus.gate;
      if (!run)
        phase <= '0;
      else if (bus.tick)
        phase <= sum[PHASE_W-1:0];
      // Tone settings only change at a period boundary once running.
      if (!env_on || (bus.tick && run && sum[PHASE_W])) begin
        inc_a  <= bus.phase_inc;
        wave_a <= wave_e'(bus.waveform);
        duty_a <= bus.duty;
      end
      valid_q <= bus.tick;
      if (bus.tick)
        out_q <= env_on ? mixed : '0;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.active    = env_on;

endmodule

// File: tb/tb_channel_nco.sv
// Randomised and directed bench for channel_nco.
// Compares every cycle against a behavioural note/phase model.
module tb_channel_nco;

  localparam int PW = 24;
  localparam int OW = 11;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  channel_nco_if #(.PHASE_W(PW), .OUT_W(OW), .ENV_W(EW)) bus ();

  channel_nco #(.PHASE_W(PW), .OUT_W(OW), .ENV_W(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  string  st;
  int     lvl;
  longint ph;
  int     inc_a, wav_a, duty_a;
  bit     gprev;
  int     m_out;
  bit     m_valid;

  function automatic int sine_ref(input int i);
    real s;
    s = $sin(2.0 * 3.14159265358979323846 * i / 256.0);
    if (i < 128) return 128 + $rtoi(127.0 * s + 0.5);
    return 127 - $rtoi(-127.0 * s + 0.5);
  endfunction

  function automatic int wave_ref(input int i, input int w, input int d);
    case (w)
      0: return (i < d) ? 255 : 0;
      1: return (i < 128) ? 2 * i : 2 * (255 - i);
      2: return sine_ref(i);
      default: return i;
    endcase
  endfunction

  function automatic void m_reset();
    st = "IDLE"; lvl = 0; ph = 0;
    inc_a = 0; wav_a = 0; duty_a = 0;
    gprev = 0; m_out = 0; m_valid = 0;
  endfunction

  function automatic void m_step();
    bit     rise, idle0, run, carry;
    int     eff, i;
    longint nph;
    if (!rst) begin
      m_reset();
      return;
    end
    rise  = bus.gate && !gprev;
    idle0 = (st == "IDLE");
    m_valid = bus.tick;
    if (bus.tick) begin
      i = int'((ph >> (PW - 8)) & 255);
      m_out = idle0 ? 0 : ((wave_ref(i, wav_a, duty_a) << (OW - 8)) * lvl) >> EW;
    end
    run   = !idle0 || rise;
    nph   = ph + longint'(inc_a);
    carry = nph >= (64'd1 << PW);
    if (!run) ph = 0;
    else if (bus.tick) ph = nph % (64'd1 << PW);
    if (idle0 || (bus.tick && run && carry)) begin
      inc_a  = int'(bus.phase_inc);
      wav_a  = int'(bus.waveform);
      duty_a = int'(bus.duty);
    end
    if (rise && (st == "IDLE" || st == "RELEASE")) st = "ATTACK";
    else if (!bus.gate && (st == "ATTACK" || st == "SUSTAIN")) st = "RELEASE";
    if (bus.tick) begin
      eff = (bus.env_rate == 0) ? 1 : int'(bus.env_rate);
      if (st == "ATTACK") begin
        lvl = (lvl + eff > 255) ? 255 : lvl + eff;
        if (lvl == 255) st = "SUSTAIN";
      end else if (st == "RELEASE") begin
        lvl = (lvl - eff < 0) ? 0 : lvl - eff;
        if (lvl == 0) st = "IDLE";
      end
    end
    gprev = bus.gate;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit t);
    bus.tick = t;
    @(posedge clk);
    m_step();
    #1;
    chk("out", 32'(bus.out), 32'(m_out));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("active", 32'(bus.active), (st != "IDLE") ? 32'd1 : 32'd0);
    chk("level", 32'(dut.level), 32'(lvl));
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic run(input int n, input int per);
    for (int k = 0; k < n; k++) begin
      for (int j = 1; j < per; j++) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  initial begin
    m_reset();
    rst = 1'b0;
    bus.tick = 0; bus.gate = 0; bus.phase_inc = '0;
    bus.waveform = 2'b00; bus.duty = 8'd0; bus.env_rate = '0;
    repeat (3) cyc(1'b1);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;

    // saw at one index step per tick, fast attack
    bus.phase_inc = 24'h010000; bus.waveform = 2'b11; bus.env_rate = 8'd255;
    cyc(1'b0);
    bus.gate = 1'b1;
    cyc(1'b1);
    chk("atk_one_tick", 32'(dut.level), 32'd255);
    run(99, 1);
    chk("saw_idx100", 32'(dut.phase[23:16]), 32'd100);
    bus.phase_inc = 24'h020000;
    run(200, 1);

    // pulse with duty 64, then duty 0
    bus.waveform = 2'b00; bus.duty = 8'd64;
    run(300, 1);
    bus.duty = 8'd0;
    run(300, 1);

    // triangle, then sine swept over every index
    bus.waveform = 2'b01; bus.phase_inc = 24'h030000;
    run(200, 1);
    bus.waveform = 2'b10; bus.phase_inc = 24'h010000;
    run(520, 2);

    // rate 16 release and attack timing
    bus.env_rate = 8'd16; bus.gate = 1'b0;
    run(16, 1);
    cyc(1'b0);
    chk("rel16_idle", 32'(bus.active), 32'd0);
    bus.gate = 1'b1;
    run(16, 1);
    chk("atk16_level", 32'(dut.level), 32'd255);
    bus.gate = 1'b0;
    run(16, 1);
    cyc(1'b0);
    chk("rel16_done", 32'(bus.active), 32'd0);

    // re-attack out of release at level 100
    bus.env_rate = 8'd5; bus.gate = 1'b1;
    run(52, 1);
    bus.gate = 1'b0;
    run(31, 1);
    chk("rel_at_100", 32'(dut.level), 32'd100);
    bus.gate = 1'b1;
    run(1, 1);
    chk("reattack_105", 32'(dut.level), 32'd105);

    // reset mid-sustain aborts at once
    bus.env_rate = 8'd16;
    run(20, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_out", 32'(bus.out), 32'd0);
    chk("abort_active", 32'(bus.active), 32'd0);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    m_reset();
    @(negedge clk);
    cyc(1'b0);
    rst = 1'b1;
    cyc(1'b1);
    chk("post_rst_atk", 32'(dut.level), 32'd16);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) bus.gate = ~bus.gate;
      if ($urandom_range(0, 49) == 0) bus.phase_inc = 24'($urandom);
      if ($urandom_range(0, 49) == 0) bus.waveform = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) bus.duty = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) bus.env_rate = 8'($urandom_range(0, 40));
      cyc(1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
